seq_divider: RTL

- Parametrised, multi-cycle unsigned restoring divider computing quotient and remainder of `dividend / divisor`.
- Computes one quotient bit per clock through a shift-subtract datapath.
- Uses a start/busy/done handshake and flags divide-by-zero with fixed, defined outputs (no high-Z).
- Serves as the shared arithmetic unit for datapaths that can tolerate multi-cycle latency.

---
 rtl/seq_divider_pkg.sv | 13 +
 rtl/div_step.sv | 29 ++
 rtl/seq_divider.sv | 123 ++++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Imported by the step datapath and the top-level FSM.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_step.sv
// One shift-compare-subtract iteration of the restoring divider.
// Purely combinational; the caller keeps r < divisor between steps.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;
  logic           ge;

  // With r < divisor the difference is below 2^WIDTH when trial >= divisor,
  // so its top bit acts as the borrow of the WIDTH+1-bit compare.
  always_comb begin
    trial  = {r, q[WIDTH-1]};
    diff   = trial - {1'b0, divisor};
    ge     = ~diff[WIDTH];
    r_next = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    q_next = {q[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// start/busy/done handshake; divide-by-zero completes in one cycle.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             error
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] r_nx, q_nx;
  logic             accept;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r       (r_q),
    .q       (q_q),
    .divisor (dvs_q),
    .r_next  (r_nx),
    .q_next  (q_nx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    accept  = start && (state_q != RUN);
    unique case (state_q)
      RUN: begin
        r_d   = r_nx;
        q_d   = q_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          quot_d  = q_nx;
          rem_d   = r_nx;
          err_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        if (accept) begin
          q_d   = dividend;
          dvs_d = divisor;
          r_d   = '0;
          cnt_d = '0;
          if (divisor == '0) begin
            state_d = DONE;
            quot_d  = DIV0_QUOT[WIDTH-1:0];
            rem_d   = dividend;
            err_d   = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign quot  = quot_q;
  assign rem   = rem_q;
  assign error = err_q;

endmodule
